// File: rtl/param_register_file_if.sv
// rtl/param_register_file_if.sv - write/read bus between the datapath and param_register_file
interface param_register_file_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   I;
    logic [2:0]          FunSel;
    logic [NUM_REGS-1:0] RegEn;
    logic [SEL_W-1:0]    OutASel;
    logic [SEL_W-1:0]    OutBSel;
    logic [DATA_W-1:0]   OutA;
    logic [DATA_W-1:0]   OutB;
    logic                Wrap;

    modport master (
        output I, FunSel, RegEn, OutASel, OutBSel,
        input  OutA, OutB, Wrap
    );

    modport slave (
        input  I, FunSel, RegEn, OutASel, OutBSel,
        output OutA, OutB, Wrap
    );
endinterface

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - NUM_REGS x DATA_W register file, shared function-select write, two read ports
// Optional feature macro RF_BYPASS_EN: write-first capture for registered read ports (READ_LAT=1).
module param_register_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int READ_LAT = 0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    param_register_file_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_REGS);
    localparam int HALF  = (DATA_W >= 16) ? 8 : DATA_W / 2;
    localparam logic [DATA_W-1:0] LO_MASK = DATA_W'((64'd1 << HALF) - 64'd1);
    localparam logic [DATA_W-1:0] HI_MASK = LO_MASK << HALF;
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

`ifdef RF_BYPASS_EN
    localparam bit USE_NEXT = (READ_LAT == 1);
`else
    localparam bit USE_NEXT = 1'b0;
`endif

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wrap_q;
    logic              wrap_d;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    always_comb begin
        wrap_d = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
            if (bus.RegEn[r]) begin
                case (bus.FunSel)
                    3'b000: begin
                        regs_d[r] = regs_q[r] - ONE;
                        if (regs_q[r] == '0) wrap_d = 1'b1;
                    end
                    3'b001: begin
                        regs_d[r] = regs_q[r] + ONE;
                        if (regs_q[r] == '1) wrap_d = 1'b1;
                    end
                    3'b010: regs_d[r] = bus.I;
                    3'b011: regs_d[r] = '0;
                    3'b100: regs_d[r] = (regs_q[r] & ~LO_MASK) | (bus.I & LO_MASK);
                    3'b101: regs_d[r] = (regs_q[r] & ~HI_MASK) | ((bus.I & LO_MASK) << HALF);
                    default: regs_d[r] = regs_q[r];
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
            wrap_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
            wrap_q <= wrap_d;
        end
    end

    // Unmatched selects (depth not a power of two) fall through to zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (bus.OutASel == SEL_W'(r)) rd_a = USE_NEXT ? regs_d[r] : regs_q[r];
            if (bus.OutBSel == SEL_W'(r)) rd_b = USE_NEXT ? regs_d[r] : regs_q[r];
        end
    end

    generate
        if (READ_LAT == 1) begin : g_reg_read
            logic [DATA_W-1:0] out_a_q;
            logic [DATA_W-1:0] out_b_q;

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    out_a_q <= '0;
                    out_b_q <= '0;
                end else begin
                    out_a_q <= rd_a;
                    out_b_q <= rd_b;
                end
            end

            assign bus.OutA = out_a_q;
            assign bus.OutB = out_b_q;
        end else begin : g_comb_read
            assign bus.OutA = rd_a;
            assign bus.OutB = rd_b;
        end
    endgenerate

    assign bus.Wrap = wrap_q;
endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - directed self-checking bench for param_register_file
module tb_param_register_file;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] i_s;
    logic [2:0]  fun_s;
    logic [7:0]  en_s;
    logic [2:0]  asel_s;
    logic [2:0]  bsel_s;
    int          total = 0;
    int          bad   = 0;

    always #5 Clock = ~Clock;

    param_register_file_if #(.DATA_W(16), .NUM_REGS(8)) if0 ();
    param_register_file_if #(.DATA_W(16), .NUM_REGS(8)) if1 ();
    param_register_file_if #(.DATA_W(16), .NUM_REGS(6)) if2 ();

    assign if0.I = i_s;  assign if0.FunSel = fun_s;  assign if0.RegEn = en_s;
    assign if0.OutASel = asel_s;  assign if0.OutBSel = bsel_s;
    assign if1.I = i_s;  assign if1.FunSel = fun_s;  assign if1.RegEn = en_s;
    assign if1.OutASel = asel_s;  assign if1.OutBSel = bsel_s;
    assign if2.I = i_s;  assign if2.FunSel = fun_s;  assign if2.RegEn = en_s[5:0];
    assign if2.OutASel = asel_s;  assign if2.OutBSel = bsel_s;

    param_register_file #(.DATA_W(16), .NUM_REGS(8), .READ_LAT(0)) dut0 (.Clock(Clock), .Reset(Reset), .bus(if0));
    param_register_file #(.DATA_W(16), .NUM_REGS(8), .READ_LAT(1)) dut1 (.Clock(Clock), .Reset(Reset), .bus(if1));
    param_register_file #(.DATA_W(16), .NUM_REGS(6), .READ_LAT(0)) dut2 (.Clock(Clock), .Reset(Reset), .bus(if2));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic op(input logic [2:0] f, input logic [15:0] d, input logic [7:0] en);
        fun_s = f; i_s = d; en_s = en;
        step();
        en_s = 8'h00;
    endtask

    task automatic rd0(input string tag, input logic [2:0] sel, input logic [15:0] exp);
        asel_s = sel; bsel_s = sel;
        #1;
        chk({tag, "_a"}, if0.OutA, exp);
        chk({tag, "_b"}, if0.OutB, exp);
    endtask

    initial begin
        Reset = 1'b1; i_s = 16'hFFFF; fun_s = 3'b010; en_s = 8'hFF; asel_s = 3'd0; bsel_s = 3'd0;
        step();
        step();
        Reset = 1'b0; en_s = 8'h00;
        for (int r = 0; r < 8; r++) rd0($sformatf("rst_r%0d", r), 3'(r), 16'h0000);
        chk("rst_wrap", {15'd0, if0.Wrap}, 16'h0000);
        chk("rst_lat1_a", if1.OutA, 16'h0000);

        op(3'b010, 16'hBEEF, 8'b0000_0101);
        rd0("load_r0", 3'd0, 16'hBEEF);
        rd0("load_r1", 3'd1, 16'h0000);
        rd0("load_r2", 3'd2, 16'hBEEF);

        op(3'b010, 16'hFFFF, 8'b0000_1000);
        op(3'b001, 16'h0000, 8'b0000_1000);
        rd0("inc_wrap_r3", 3'd3, 16'h0000);
        chk("inc_wrap_pulse", {15'd0, if0.Wrap}, 16'h0001);
        step();
        chk("wrap_not_sticky", {15'd0, if0.Wrap}, 16'h0000);
        op(3'b001, 16'h0000, 8'b0000_1000);
        rd0("inc_r3", 3'd3, 16'h0001);
        chk("inc_no_wrap", {15'd0, if0.Wrap}, 16'h0000);
        op(3'b000, 16'h0000, 8'b0000_1000);
        rd0("dec_r3", 3'd3, 16'h0000);
        chk("dec_no_wrap", {15'd0, if0.Wrap}, 16'h0000);
        op(3'b000, 16'h0000, 8'b0000_1000);
        rd0("dec_wrap_r3", 3'd3, 16'hFFFF);
        chk("dec_wrap_pulse", {15'd0, if0.Wrap}, 16'h0001);

        op(3'b001, 16'h0000, 8'b0000_0101);
        rd0("multi_inc_r0", 3'd0, 16'hBEF0);
        rd0("multi_inc_r2", 3'd2, 16'hBEF0);

        op(3'b010, 16'h1234, 8'b0010_0000);
        op(3'b100, 16'h00AB, 8'b0010_0000);
        rd0("load_low_r5", 3'd5, 16'h12AB);
        op(3'b101, 16'h00CD, 8'b0010_0000);
        rd0("load_high_r5", 3'd5, 16'hCDAB);
        op(3'b110, 16'h5555, 8'hFF);
        rd0("hold_r5", 3'd5, 16'hCDAB);
        rd0("hold_r2", 3'd2, 16'hBEF0);

        bsel_s = 3'd5; #1;
        chk("n6_sel5", if2.OutB, 16'hCDAB);
        bsel_s = 3'd6; #1;
        chk("n6_sel6", if2.OutB, 16'h0000);
        bsel_s = 3'd7; #1;
        chk("n6_sel7", if2.OutB, 16'h0000);

        op(3'b011, 16'hFFFF, 8'b0010_0000);
        rd0("clear_r5", 3'd5, 16'h0000);

        asel_s = 3'd1;
        op(3'b010, 16'h0001, 8'b0000_0010);
        step();
        chk("lat1_pre", if1.OutA, 16'h0001);
        op(3'b010, 16'h0055, 8'b0000_0010);
`ifdef RF_BYPASS_EN
        chk("lat1_write_edge", if1.OutA, 16'h0055);
`else
        chk("lat1_write_edge", if1.OutA, 16'h0001);
`endif
        step();
        chk("lat1_next_edge", if1.OutA, 16'h0055);

        Reset = 1'b1; fun_s = 3'b010; i_s = 16'hA5A5; en_s = 8'hFF;
        step();
        Reset = 1'b0; en_s = 8'h00;
        for (int r = 0; r < 8; r++) rd0($sformatf("rst2_r%0d", r), 3'(r), 16'h0000);
        chk("rst2_lat1_a", if1.OutA, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
